// File: rtl/axi_hp_stream_writer_if.sv
// AXI3 HP port bundle between a write master and a Zynq HP slave.
// Parameter ID_WIDTH sizes the AXI ID fields on every channel.
// Modports: master (drives AW/W/AR, bready and rready) and slave (the opposite).
interface axi_hp_interface #(
    parameter int ID_WIDTH = 6
);
    logic [ID_WIDTH-1:0] awid;
    logic [31:0]         awaddr;
    logic [3:0]          awlen;
    logic [2:0]          awsize;
    logic [1:0]          awburst;
    logic [1:0]          awlock;
    logic [3:0]          awcache;
    logic [2:0]          awprot;
    logic [3:0]          awqos;
    logic                awvalid;
    logic                awready;

    logic [ID_WIDTH-1:0] wid;
    logic [63:0]         wdata;
    logic [7:0]          wstrb;
    logic                wlast;
    logic                wvalid;
    logic                wready;

    logic [ID_WIDTH-1:0] bid;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;

    logic [ID_WIDTH-1:0] arid;
    logic [31:0]         araddr;
    logic [3:0]          arlen;
    logic [2:0]          arsize;
    logic [1:0]          arburst;
    logic [1:0]          arlock;
    logic [3:0]          arcache;
    logic [2:0]          arprot;
    logic [3:0]          arqos;
    logic                arvalid;
    logic                arready;

    logic [ID_WIDTH-1:0] rid;
    logic [63:0]         rdata;
    logic [1:0]          rresp;
    logic                rlast;
    logic                rvalid;
    logic                rready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready,
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awqos, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready,
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arqos, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready
    );
endinterface

// File: rtl/axi_hp_stream_writer.sv
// Streaming write master: buffers a 64-bit valid/ready stream in a FWFT FIFO and
// writes it into a DDR ring buffer as fixed-length AXI3 INCR bursts, one burst
// outstanding at a time.
// Ports: clk/resetn (async active-low), enable (recording level), base_addr/size_bytes
// (ring geometry), s_data/s_valid/s_ready (input stream), wr_ptr/wrap_cnt/err/busy
// (status), m (AXI HP master port).
//
// state  | meaning
// IDLE   | waiting for a full burst in the FIFO while enabled
// ADDR   | awvalid held until awready
// DATA   | streaming FIFO head on W, wlast on the final beat
// RESP   | bready held until bvalid; ring offset advances on the handshake
module axi_hp_stream_writer #(
    parameter int ID_WIDTH   = 6,
    parameter int AXI_ID     = 0,
    parameter int BURST_LEN  = 16,
    parameter int FIFO_DEPTH = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic [31:0] base_addr,
    input  logic [31:0] size_bytes,
    input  logic [63:0] s_data,
    input  logic        s_valid,
    output logic        s_ready,
    output logic [31:0] wr_ptr,
    output logic [15:0] wrap_cnt,
    output logic        err,
    output logic        busy,
    axi_hp_interface.master m
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * 8);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_ADDR = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]    state;
    logic [63:0]   mem [FIFO_DEPTH];
    logic [AW-1:0] wr_idx, rd_idx, wr_base, rd_base;
    logic [CW-1:0] count, cnt_base, count_n;
    logic          push, pop, flush, b_hs, launch;
    logic          en_q, start_req, start_pend;
    logic          aw_valid_q, w_valid_q, w_last_q, b_ready_q;
    logic [31:0]   aw_addr_q, offset, off_adv;
    logic [3:0]    beat;

    assign push      = s_valid && s_ready;
    assign pop       = (state == S_DATA) && w_valid_q && m.wready;
    assign b_hs      = (state == S_RESP) && b_ready_q && m.bvalid;
    assign start_req = enable && !en_q;
    // A start seen mid-burst is deferred and lands on the B handshake, so the
    // FSM re-enters IDLE with the ring and FIFO already cleared.
    assign flush     = ((state == S_IDLE) || b_hs) && (start_req || start_pend);
    assign launch    = (state == S_IDLE) && enable && !flush && (count >= CW'(BURST_LEN));
    assign off_adv   = offset + BURST_BYTES;

    // A push in the flush cycle is kept as the first word of the new recording.
    always_comb begin
        wr_base  = flush ? '0 : wr_idx;
        rd_base  = flush ? '0 : rd_idx;
        cnt_base = flush ? '0 : count;
        count_n  = cnt_base + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_base] <= s_data;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_idx     <= '0;
            rd_idx     <= '0;
            count      <= '0;
            s_ready    <= 1'b0;
            en_q       <= 1'b0;
            start_pend <= 1'b0;
            offset     <= '0;
            wrap_cnt   <= '0;
            err        <= 1'b0;
        end else begin
            wr_idx  <= wr_base + AW'(push);
            rd_idx  <= rd_base + AW'(pop);
            count   <= count_n;
            s_ready <= (count_n != CW'(FIFO_DEPTH));
            en_q    <= enable;
            if (flush)          start_pend <= 1'b0;
            else if (start_req) start_pend <= 1'b1;
            if (flush) begin
                offset   <= '0;
                wrap_cnt <= '0;
                err      <= 1'b0;
            end else if (b_hs) begin
                if (off_adv == size_bytes) begin
                    offset <= '0;
                    if (wrap_cnt != 16'hFFFF) wrap_cnt <= wrap_cnt + 16'd1;
                end else begin
                    offset <= off_adv;
                end
                if (m.bresp != 2'b00) err <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= S_IDLE;
            aw_valid_q <= 1'b0;
            aw_addr_q  <= '0;
            w_valid_q  <= 1'b0;
            w_last_q   <= 1'b0;
            b_ready_q  <= 1'b0;
            beat       <= '0;
        end else begin
            case (state)
                S_IDLE: if (launch) begin
                    aw_valid_q <= 1'b1;
                    aw_addr_q  <= base_addr + offset;
                    state      <= S_ADDR;
                end
                S_ADDR: if (m.awready) begin
                    aw_valid_q <= 1'b0;
                    w_valid_q  <= 1'b1;
                    w_last_q   <= 1'b0;
                    beat       <= '0;
                    state      <= S_DATA;
                end
                S_DATA: if (m.wready) begin
                    if (w_last_q) begin
                        w_valid_q <= 1'b0;
                        w_last_q  <= 1'b0;
                        b_ready_q <= 1'b1;
                        state     <= S_RESP;
                    end else begin
                        beat     <= beat + 4'd1;
                        w_last_q <= (beat == 4'(BURST_LEN - 2));
                    end
                end
                default: if (m.bvalid) begin
                    b_ready_q <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state != S_IDLE);
    assign wr_ptr = offset;

    assign m.awid    = ID_WIDTH'(AXI_ID);
    assign m.awaddr  = aw_addr_q;
    assign m.awlen   = 4'(BURST_LEN - 1);
    assign m.awsize  = 3'b011;
    assign m.awburst = 2'b01;
    assign m.awlock  = 2'b00;
    assign m.awcache = 4'b0011;
    assign m.awprot  = 3'b000;
    assign m.awqos   = 4'b0000;
    assign m.awvalid = aw_valid_q;

    assign m.wid    = ID_WIDTH'(AXI_ID);
    assign m.wdata  = mem[rd_idx];
    assign m.wstrb  = 8'hFF;
    assign m.wlast  = w_last_q;
    assign m.wvalid = w_valid_q;
    assign m.bready = b_ready_q;

    assign m.arid    = '0;
    assign m.araddr  = '0;
    assign m.arlen   = '0;
    assign m.arsize  = '0;
    assign m.arburst = '0;
    assign m.arlock  = '0;
    assign m.arcache = '0;
    assign m.arprot  = '0;
    assign m.arqos   = '0;
    assign m.arvalid = 1'b0;
    assign m.rready  = 1'b0;

    logic unused_sink;
    assign unused_sink = ^{m.bid, m.arready, m.rid, m.rdata, m.rresp, m.rlast, m.rvalid};
endmodule
